// File: rtl/bitcounter_param.sv
// ----------------------------------------------------------------------------
// bitcounter_param
// Counts the set bits (mode = 0) or the clear bits (mode = 1) of a WIDTH-bit
// operand. The operand is latched into a shift register A; each cycle in
// S_SHIFT the LSB is added into result and A shifts right. The count ends as
// soon as A reaches zero, so the latency depends on the highest set bit.
//
// Handshake: start is a level request, sampled only in S_IDLE and S_DONE.
//   - In S_IDLE, start = 1 loads the operand and begins a count.
//   - done stays high in S_DONE until start has been seen low, so a request
//     held high cannot re-trigger a second count.
//   - result is valid while done = 1, and holds its value until the next load.
//
// Ports:
//   clock      in   rising-edge system clock
//   reset_n    in   asynchronous active-low reset
//   start      in   level request
//   mode       in   0 = count ones, 1 = count zeros (latched at load)
//   data_in    in   [WIDTH-1:0] operand (latched at load)
//   ready      out  high in S_IDLE
//   busy       out  high in S_SHIFT
//   done       out  high in S_DONE
//   result     out  [CNT_W-1:0] bit count
//   dbg_state  out  [1:0] current FSM state encoding (debug visibility)
// ----------------------------------------------------------------------------
module bitcounter_param #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] data_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] result,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [CNT_W-1:0] result_q, result_d;

   // Next-state and datapath.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               // Counting zeros is counting ones of the inverted operand.
               a_d      = mode ? ~data_in : data_in;
               result_d = '0;
               state_d  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (a_q == '0) begin
               state_d = S_DONE;
            end else begin
               a_d = a_q >> 1;
               if (a_q[0]) begin
                  result_d = result_q + CNT_W'(1);
               end
            end
         end
         S_DONE: begin
            // Wait for start to drop before accepting another request.
            if (!start) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         result_q <= result_d;
      end
   end

   // Moore outputs decoded from state only.
   assign ready     = (state_q == S_IDLE);
   assign busy      = (state_q == S_SHIFT);
   assign done      = (state_q == S_DONE);
   assign result    = result_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_bitcounter_param.sv
// ----------------------------------------------------------------------------
// tb_bitcounter_param
// Drives an 8-bit and a 16-bit instance of bitcounter_param with directed and
// random operations and compares result, done latency and busy length against
// a reference computed from the operand bits.
// ----------------------------------------------------------------------------
module tb_bitcounter_param;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic        start8 = 1'b0, mode8 = 1'b0;
   logic [7:0]  data8 = '0;
   logic        ready8, busy8, done8;
   logic [3:0]  result8;
   logic [1:0]  dbg8;

   logic        start16 = 1'b0, mode16 = 1'b0;
   logic [15:0] data16 = '0;
   logic        ready16, busy16, done16;
   logic [4:0]  result16;
   logic [1:0]  dbg16;

   bitcounter_param #(.WIDTH(8)) dut8 (
      .clock(clk), .reset_n(reset_n), .start(start8), .mode(mode8),
      .data_in(data8), .ready(ready8), .busy(busy8), .done(done8),
      .result(result8), .dbg_state(dbg8)
   );

   bitcounter_param #(.WIDTH(16), .CNT_W(5)) dut16 (
      .clock(clk), .reset_n(reset_n), .start(start16), .mode(mode16),
      .data_in(data16), .ready(ready16), .busy(busy16), .done(done16),
      .result(result16), .dbg_state(dbg16)
   );

   // ---------------- scoreboard counters ----------------
   int n_compared = 0;
   int n_mismatch = 0;
   bit x_watch = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      assert (got === exp)
      else begin
         n_mismatch++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // No output may be X once reset has been released.
   always @(negedge clk) begin
      if (x_watch && reset_n) begin
         check("no_x", 32'($isunknown({ready8, busy8, done8, result8,
                                       ready16, busy16, done16, result16})), 32'd0);
      end
   end

   // ---------------- reference model ----------------
   // Operand as seen by the counter, restricted to w bits.
   function automatic logic [15:0] eff_operand(input int w, input logic [15:0] d, input logic m);
      logic [15:0] v;
      v = m ? ~d : d;
      for (int i = w; i < 16; i++) v[i] = 1'b0;
      return v;
   endfunction

   function automatic int ref_count(input logic [15:0] v);
      int c = 0;
      for (int i = 0; i < 16; i++) if (v[i]) c++;
      return c;
   endfunction

   // Number of significant bits (highest set index + 1, or 0 when zero).
   function automatic int ref_k(input logic [15:0] v);
      int k = 0;
      for (int i = 0; i < 16; i++) if (v[i]) k = i + 1;
      return k;
   endfunction

   // ---------------- DUT accessors ----------------
   function automatic logic get_done(input int w);
      return (w == 8) ? done8 : done16;
   endfunction
   function automatic logic get_busy(input int w);
      return (w == 8) ? busy8 : busy16;
   endfunction
   function automatic logic get_ready(input int w);
      return (w == 8) ? ready8 : ready16;
   endfunction
   function automatic logic [31:0] get_result(input int w);
      return (w == 8) ? 32'(result8) : 32'(result16);
   endfunction

   task automatic drive(input int w, input logic s, input logic m, input logic [15:0] d);
      if (w == 8) begin
         start8 = s; mode8 = m; data8 = d[7:0];
      end else begin
         start16 = s; mode16 = m; data16 = d;
      end
   endtask

   // ---------------- driver: one full count ----------------
   task automatic do_count(input string tag, input int w, input logic [15:0] d,
                           input logic m, input bit mid_change);
      logic [15:0] v;
      int exp_cnt, k, edges, busy_n;
      bit seen;
      v       = eff_operand(w, d, m);
      exp_cnt = ref_count(v);
      k       = ref_k(v);
      @(negedge clk);
      drive(w, 1'b1, m, d);
      edges = 0; busy_n = 0; seen = 1'b0;
      while (!seen && edges < 40) begin
         @(posedge clk);
         edges++;
         #1;
         if (get_done(w)) seen = 1'b1;
         else if (get_busy(w)) busy_n++;
         // Operand changes after the load edge must not affect the count.
         if (edges == 1 && mid_change) drive(w, 1'b1, ~m, 16'(~d) ^ 16'($urandom));
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_done_edge"}, 32'(edges), 32'(k + 2));
      check({tag, "_busy_len"},  32'(busy_n), 32'(k + 1));
      check({tag, "_result"},    get_result(w), 32'(exp_cnt));
      // start still high: stays done, result held.
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_hold_done"},   32'(get_done(w)), 32'd1);
      check({tag, "_hold_result"}, get_result(w), 32'(exp_cnt));
      @(negedge clk);
      drive(w, 1'b0, m, d);
      @(posedge clk);
      #1;
      check({tag, "_ready_after"},  32'(get_ready(w)), 32'd1);
      check({tag, "_result_kept"},  get_result(w), 32'(exp_cnt));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready8"},  32'(ready8), 32'd1);
      check({tag, "_busy8"},   32'(busy8), 32'd0);
      check({tag, "_done8"},   32'(done8), 32'd0);
      check({tag, "_result8"}, 32'(result8), 32'd0);
      check({tag, "_ready16"}, 32'(ready16), 32'd1);
      check({tag, "_result16"}, 32'(result16), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset held low for 2 cycles; values checked while low and after.
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("rst_low");
      @(negedge clk);
      reset_n = 1'b1;
      x_watch = 1'b1;
      @(posedge clk);
      #1;
      check_reset_vals("rst_release");

      // Directed cases.
      do_count("ff_ones",   8, 16'h00FF, 1'b0, 1'b0);
      do_count("zero",      8, 16'h0000, 1'b0, 1'b0);
      do_count("z81_zeros", 8, 16'h0081, 1'b1, 1'b0);
      do_count("mid_chg",   8, 16'h0005, 1'b0, 1'b1);
      do_count("w16_a5a5", 16, 16'hA5A5, 1'b0, 1'b0);
      do_count("w16_ffff", 16, 16'hFFFF, 1'b1, 1'b0);

      // Reset mid-count: takes effect without a clock edge.
      @(negedge clk);
      drive(8, 1'b1, 1'b0, 16'h00F0);
      repeat (4) @(posedge clk);
      #2;
      check("midrst_busy_before", 32'(busy8), 32'd1);
      reset_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      @(negedge clk);
      drive(8, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      reset_n = 1'b1;
      do_count("after_rst", 8, 16'h000F, 1'b0, 1'b0);

      // Random operations on both widths.
      for (int i = 0; i < 24; i++) begin
         int w;
         w = ($urandom_range(0, 1) == 0) ? 8 : 16;
         do_count($sformatf("rnd%0d", i), w, 16'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
      end

      x_watch = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule

// File: doc/bitcounter_param.md
Name: bitcounter_param

Overview:
- Self-contained, parametrised bit-counter: FSM plus datapath in one block.
- Counts set bits (mode 0) or clear bits (mode 1) of a WIDTH-bit operand.
- Start/done handshake; terminates early once the shift register reaches zero.
- Next-generation replacement for the fixed 8-bit counter datapath with external control; used by the lab top level, which drives it from switches and keys and displays `result` on the HEX displays.

Parameters:
- WIDTH, default 8: operand width in bits; legal range ≥ 2.
- CNT_W, default $clog2(WIDTH+1): result width; must hold the value WIDTH (WIDTH=8 -> 4).

Ports:
- clock  input  1  50 MHz system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  level request; sampled only in S_IDLE and S_DONE.
- mode  input  1  0 = count ones, 1 = count zeros; latched at load.
- data_in  input  WIDTH  operand; latched at load.
- ready  output  1  high in S_IDLE.
- busy  output  1  high in S_SHIFT.
- done  output  1  high in S_DONE.
- result  output  CNT_W  count; stable from entry to S_DONE until the next load.

Behaviour:
- Reset is asynchronous, active-low, and may occur at any cycle, including mid-count. It forces:
  - state = S_IDLE
  - internal shift register A = 0
  - result = 0
  - ready = 1, busy = 0, done = 0
- State encoding: S_IDLE, S_SHIFT, S_DONE. Outputs are Moore-style, decoded from state only.
- S_IDLE:
  - If start = 1: load A <= (mode ? ~data_in : data_in), result <= 0, next state S_SHIFT.
  - Otherwise hold. result keeps its previous value, so the last count stays displayed.
- S_SHIFT, evaluated once per cycle on registered A:
  - If A == 0: next state S_DONE; A and result unchanged.
  - Otherwise: A <= A >> 1 (logical, zero fill); if A[0] = 1 then result <= result + 1.
- S_DONE:
  - done = 1, result held.
  - start = 0: next state S_IDLE.
  - start = 1: remain in S_DONE. No re-trigger until start has been seen low.
- Ignored inputs:
  - start, mode and data_in are ignored in S_SHIFT.
  - Changes to data_in or mode after the load edge have no effect on the current count.
- Latency: let h be the index of the highest set bit of the loaded A, and k = h+1 (k = 0 if A == 0).
  - S_SHIFT lasts exactly k+1 cycles.
  - done rises on the (k+2)th rising edge counting the start-sampling edge as edge 1.
  - Worst case (MSB set): WIDTH+2 edges.
- Arithmetic: result never exceeds WIDTH, so no wrap occurs. An increment is impossible once A == 0.
- Reset during S_SHIFT or S_DONE: partial count discarded, result = 0, block returns to S_IDLE immediately (asynchronous).
- No X propagation: A and result are fully defined after reset; the bench checks that no output is ever X after reset release.

Test Plan:
- Reset release: reset_n low for 2 cycles then high, start = 0 -> ready = 1, busy = 0, done = 0, result = 0; the same values hold while reset_n is low.
- WIDTH=8, mode=0, data_in=8'hFF, start held high:
  - busy = 1 for 9 cycles; done rises on edge 10 with result = 8.
  - State stays in S_DONE while start = 1.
  - start low -> ready = 1 next cycle, result still 8.
- WIDTH=8, mode=0, data_in=8'h00 -> done on edge 2, result = 0. Then mode=1, data_in=8'h81 -> result = 6, done on edge 9 (A = 8'h7E, k = 7).
- WIDTH=8, mode=0, data_in=8'h05; during S_SHIFT change data_in to 8'hFF and toggle mode -> result = 2, done on edge 5.
- WIDTH=16 instance, CNT_W=5, data_in=16'hA5A5, mode=0 -> result = 8, done on edge 18. Then data_in=16'hFFFF, mode=1 -> result = 0, done on edge 2.
- Reset mid-count: WIDTH=8, data_in=8'hF0, assert reset_n low 4 cycles after start -> outputs return to reset values without a clock edge. A new start with 8'h0F then gives result = 4 on edge 6.
